// File: rtl/parity_serial_tx_pkg.sv
// Shared types and constants for the parity-framed serial transmitter.
package parity_serial_tx_pkg;

    // Frame sequencing: one start bit, eight data bits, parity, one stop bit
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txState_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/parity_serial_tx_if.sv
// Byte handshake between an upstream producer and the serial transmitter.
interface parity_serial_tx_if;
    import parity_serial_tx_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/parity_serial_tx_parity_generator.sv
// 8-bit combinational parity generator; provides both parity senses.
module parity_generator (
    input  logic [7:0] data,
    output logic       evenParity,
    output logic       oddParity
);
    // evenParity makes the total count of ones even, oddParity makes it odd
    assign evenParity = ^data;
    assign oddParity  = ~(^data);
endmodule

// File: rtl/parity_serial_tx.sv
// Byte-wide serial transmitter: start, d0..d7 LSB first, parity, stop.
// Every line-level output comes straight from a flop.
module parity_serial_tx
    import parity_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    parity_serial_tx_if.slave   txBus,
    output logic                tx_serial,
    output logic                busy,
    output logic                parity_sent
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    txState_t             state;
    logic [CNT_W-1:0]     cycCnt;
    logic [IDX_W-1:0]     bitIdx;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 evenPar;
    logic                 oddPar;
    logic                 newParity;
    logic                 bitDone;

    parity_generator uParGen (
        .data       (txBus.tx_data),
        .evenParity (evenPar),
        .oddParity  (oddPar)
    );

    assign newParity = PARITY_ODD ? oddPar : evenPar;
    assign bitDone   = (cycCnt == LAST_CNT);

    // Frame FSM with registered line, handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            tx_serial      <= LINE_IDLE;
            txBus.tx_ready <= 1'b1;
            busy           <= 1'b0;
            parity_sent    <= 1'b0;
            cycCnt         <= '0;
            bitIdx         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cycCnt <= '0;
                    bitIdx <= '0;
                    if (txBus.tx_valid && txBus.tx_ready) begin
                        shiftReg       <= txBus.tx_data;
                        parity_sent    <= newParity;
                        tx_serial      <= START_LEVEL;
                        txBus.tx_ready <= 1'b0;
                        busy           <= 1'b1;
                        state          <= START;
                    end
                end
                START: begin
                    if (bitDone) begin
                        cycCnt    <= '0;
                        tx_serial <= shiftReg[0];
                        state     <= DATA;
                    end else begin
                        cycCnt <= cycCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bitDone) begin
                        cycCnt <= '0;
                        if (bitIdx == LAST_IDX) begin
                            bitIdx    <= '0;
                            tx_serial <= parity_sent;
                            state     <= PARITY;
                        end else begin
                            // Present the next bit from the pre-shift value so
                            // the line changes on the same edge as the shift
                            shiftReg  <= shiftReg >> 1;
                            tx_serial <= shiftReg[1];
                            bitIdx    <= bitIdx + 1'b1;
                        end
                    end else begin
                        cycCnt <= cycCnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bitDone) begin
                        cycCnt    <= '0;
                        tx_serial <= STOP_LEVEL;
                        state     <= STOP;
                    end else begin
                        cycCnt <= cycCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bitDone) begin
                        // The single IDLE cycle that follows separates frames
                        cycCnt         <= '0;
                        tx_serial      <= LINE_IDLE;
                        txBus.tx_ready <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        cycCnt <= cycCnt + 1'b1;
                    end
                end
                default: begin
                    cycCnt         <= '0;
                    bitIdx         <= '0;
                    tx_serial      <= LINE_IDLE;
                    txBus.tx_ready <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Bench for parity_serial_tx: an even-parity and an odd-parity instance share
// the same stimulus; accepted bytes go to per-instance scoreboards and each
// frame on the line is decoded against them.
module tb_parity_serial_tx;
    localparam int CPB = 4;
    localparam int FRAME_CYC = 11 * CPB;

    logic clk;
    logic rst;
    logic ser0, busy0, par0;
    logic ser1, busy1, par1;
    int   vectors;
    int   miscompares;
    int   cyc;

    logic [8:0] expQ0[$];
    logic [8:0] expQ1[$];

    parity_serial_tx_if bus0 ();
    parity_serial_tx_if bus1 ();

    parity_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .txBus       (bus0),
        .tx_serial   (ser0),
        .busy        (busy0),
        .parity_sent (par0)
    );

    parity_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .txBus       (bus1),
        .tx_serial   (ser1),
        .busy        (busy1),
        .parity_sent (par1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic refParity(input logic [7:0] d, input bit odd);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return logic'((ones % 2) == 1) ^ logic'(odd);
    endfunction

    // Scoreboard push on every accepted byte
    always @(posedge clk) begin
        if (!rst && bus0.tx_valid && bus0.tx_ready)
            expQ0.push_back({refParity(bus0.tx_data, 1'b0), bus0.tx_data});
        if (!rst && bus1.tx_valid && bus1.tx_ready)
            expQ1.push_back({refParity(bus1.tx_data, 1'b1), bus1.tx_data});
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic setIn(input logic v, input logic [7:0] d);
        bus0.tx_valid = v;
        bus0.tx_data  = d;
        bus1.tx_valid = v;
        bus1.tx_data  = d;
    endtask

    // Called at a negedge; returns at the negedge where the start bit is visible
    task automatic send(input logic [7:0] d);
        int guard;
        setIn(1'b1, d);
        guard = 0;
        while (bus0.tx_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) checkEq("readyTimeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        setIn(1'b0, d);
    endtask

    // Decodes one frame from both lines; returns at the first idle sample
    task automatic checkFrame(output int startCyc);
        int guard;
        logic [8:0] e0, e1;
        logic [10:0] b0, b1;
        guard = 0;
        startCyc = cyc;
        while (ser0 !== 1'b0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            checkEq("startTimeout", 32'd0, 32'd1);
            return;
        end
        startCyc = cyc;
        if (expQ0.size() == 0 || expQ1.size() == 0) begin
            checkEq("sbEmpty", 32'd0, 32'd1);
            return;
        end
        e0 = expQ0.pop_front();
        e1 = expQ1.pop_front();
        b0 = {1'b1, e0[8], e0[7:0], 1'b0};
        b1 = {1'b1, e1[8], e1[7:0], 1'b0};
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                checkEq($sformatf("line0 bit%0d", b), 32'(ser0), 32'(b0[b]));
                checkEq($sformatf("line1 bit%0d", b), 32'(ser1), 32'(b1[b]));
                checkEq("busyInFrame", 32'(busy0 & busy1), 32'd1);
                checkEq("readyInFrame", 32'(bus0.tx_ready | bus1.tx_ready), 32'd0);
                @(negedge clk);
            end
        end
        checkEq("readyAfter0", 32'(bus0.tx_ready), 32'd1);
        checkEq("readyAfter1", 32'(bus1.tx_ready), 32'd1);
        checkEq("busyAfter", 32'(busy0 | busy1), 32'd0);
        checkEq("idleLine", 32'(ser0 & ser1), 32'd1);
        checkEq("paritySent0", 32'(par0), 32'(e0[8]));
        checkEq("paritySent1", 32'(par1), 32'(e1[8]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int st1, st2, badIdle;
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        rst = 1'b1;
        setIn(1'b0, 8'h00);
        repeat (2) @(negedge clk);
        checkEq("rstSerial", 32'(ser0 & ser1), 32'd1);
        checkEq("rstReady", 32'(bus0.tx_ready & bus1.tx_ready), 32'd1);
        checkEq("rstBusy", 32'(busy0 | busy1), 32'd0);
        checkEq("rstParity", 32'(par0 | par1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single frames in both parity modes
        send(8'hA5);
        checkFrame(st1);
        @(negedge clk);
        send(8'h07);
        checkFrame(st1);
        @(negedge clk);

        // tx_valid held high: 0x00 then 0xFF back to back
        setIn(1'b1, 8'h00);
        @(posedge clk);
        @(negedge clk);
        setIn(1'b1, 8'hFF);
        checkFrame(st1);
        checkFrame(st2);
        setIn(1'b0, 8'hFF);
        checkEq("b2bPeriod", 32'(st2 - st1), 32'(FRAME_CYC + 1));
        @(negedge clk);

        // Upstream disturbance during DATA bit 3 must not affect the frame
        send(8'h3C);
        fork
            checkFrame(st1);
            begin
                repeat (16) @(negedge clk);
                setIn(1'b1, 8'h81);
                @(negedge clk);
                setIn(1'b0, 8'h81);
                @(negedge clk);
                setIn(1'b1, 8'h81);
                @(negedge clk);
                setIn(1'b0, 8'h3C);
            end
        join
        @(negedge clk);

        // Reset while the parity bit is on the line
        send(8'h0B);
        repeat (37) @(negedge clk);
        checkEq("preRstParity", 32'(ser0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkEq("abortSerial", 32'(ser0 & ser1), 32'd1);
        checkEq("abortReady", 32'(bus0.tx_ready & bus1.tx_ready), 32'd1);
        checkEq("abortBusy", 32'(busy0 | busy1), 32'd0);
        checkEq("abortParity", 32'(par0 | par1), 32'd0);
        if (expQ0.size() > 0) void'(expQ0.pop_front());
        if (expQ1.size() > 0) void'(expQ1.pop_front());
        badIdle = 0;
        repeat (60) begin
            @(negedge clk);
            if (ser0 !== 1'b1 || ser1 !== 1'b1 || busy0 !== 1'b0) badIdle++;
        end
        checkEq("noRetransmit", 32'(badIdle), 32'd0);
        send(8'h01);
        checkFrame(st1);
        @(negedge clk);

        // Reset together with tx_valid: acceptance only after release
        rst = 1'b1;
        setIn(1'b1, 8'h5A);
        @(negedge clk);
        checkEq("rstValidReady", 32'(bus0.tx_ready), 32'd1);
        checkEq("rstValidBusy", 32'(busy0), 32'd0);
        checkEq("rstValidLine", 32'(ser0), 32'd1);
        checkEq("rstValidSb", 32'(expQ0.size()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkEq("acceptAfterRst", 32'(ser0), 32'd0);
        setIn(1'b0, 8'h5A);
        checkFrame(st1);
        @(negedge clk);

        checkEq("sbDrained", 32'(expQ0.size() + expQ1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
